// File: rtl/fpu_rec_pkg.sv
// Shared recoded-F32 definitions: rounding modes, recFN exponent codes, flag positions,
// the captured raw-operation record and small rounding helpers.
package fpu_rec_pkg;

  typedef enum logic [2:0] {
    RM_RNE = 3'd0,
    RM_RTZ = 3'd1,
    RM_RDN = 3'd2,
    RM_RUP = 3'd3,
    RM_RMM = 3'd4
  } roundMode_t;

  localparam logic [8:0]  REC_EXP_MAX_FIN  = 9'h17F;
  localparam logic [8:0]  REC_EXP_INF      = 9'h180;
  localparam logic [8:0]  REC_EXP_MIN_NORM = 9'd130;
  localparam logic [8:0]  REC_EXP_SUB_BASE = 9'd107;
  localparam logic [32:0] REC_CANON_NAN    = 33'h0E0400000;

  localparam int FLAG_NV = 4;
  localparam int FLAG_DZ = 3;
  localparam int FLAG_OF = 2;
  localparam int FLAG_UF = 1;
  localparam int FLAG_NX = 0;

  typedef struct packed {
    logic        isNaN;
    logic        isInf;
    logic        isZero;
    logic        sign;
    logic [9:0]  sExp;
    logic [26:0] sig;
    roundMode_t  rm;
    logic        nv;
    logic        dz;
  } rawOp_t;

  function automatic logic roundInc(input roundMode_t rm, input logic sign, input logic lsb,
                                    input logic rnd, input logic stk);
    case (rm)
      RM_RNE:  return rnd & (stk | lsb);
      RM_RMM:  return rnd;
      RM_RUP:  return (rnd | stk) & !sign;
      RM_RDN:  return (rnd | stk) & sign;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [4:0] leadOne(input logic [23:0] v);
    logic [4:0] pos;
    pos = '0;
    for (int i = 0; i < 24; i++)
      if (v[i]) pos = 5'(i);
    return pos;
  endfunction

endpackage

// File: rtl/rec_fn_round_core.sv
// Combinational rounding of a raw div/sqrt result into 33-bit recoded F32 plus
// {NV,DZ,OF,UF,NX}; subnormals are rounded at subnormal precision then renormalized.
module rec_fn_round_core
  import fpu_rec_pkg::*;
(
  input  rawOp_t      raw,
  output logic [32:0] out,
  output logic [4:0]  flags
);

  logic signed [11:0] e, eNorm, shAmt;
  logic signed [11:0] minNorm;
  logic [23:0] m, mt;
  logic        r, s, rt, st;
  logic [4:0]  sh, lead;
  logic [50:0] wide;
  logic [24:0] mr;
  logic [22:0] normSig;
  logic [8:0]  eTiny;
  logic        tiny, inc, inexact, tinyAfter, ovf, toInf;

  always_comb begin
    if (raw.sig[26]) begin
      m = raw.sig[26:3];
      r = raw.sig[2];
      s = |raw.sig[1:0];
      e = $signed({{2{raw.sExp[9]}}, raw.sExp}) + 12'sd1;
    end else begin
      m = raw.sig[25:2];
      r = raw.sig[1];
      s = raw.sig[0];
      e = $signed({{2{raw.sExp[9]}}, raw.sExp});
    end
  end

  assign minNorm = $signed({3'b000, REC_EXP_MIN_NORM});
  assign tiny    = e < minNorm;
  assign shAmt   = minNorm - e;
  assign sh      = !tiny ? 5'd0 : ((shAmt > 12'sd26) ? 5'd26 : shAmt[4:0]);

  // Round bit rides below the kept bits; everything shifted past it folds into sticky.
  assign wide    = {m, r, 26'b0} >> sh;
  assign mt      = wide[50:27];
  assign rt      = wide[26];
  assign st      = s | (|wide[25:0]);
  assign inc     = roundInc(raw.rm, raw.sign, mt[0], rt, st);
  assign mr      = {1'b0, mt} + {24'b0, inc};
  assign inexact = rt | st;

  // Tininess after rounding: only exp 129 can reach min normal under unbounded-range rounding.
  assign tinyAfter = tiny & !((e == 12'sd129) & (&m) & roundInc(raw.rm, raw.sign, m[0], r, s));

  assign eNorm   = e + (mr[24] ? 12'sd1 : 12'sd0);
  assign ovf     = !tiny & (eNorm > 12'sd383);
  assign lead    = leadOne(mr[23:0]);
  assign normSig = mr[22:0] << (5'd23 - lead);
  assign eTiny   = REC_EXP_SUB_BASE + {4'b0, lead};
  assign toInf   = (raw.rm == RM_RNE) | (raw.rm == RM_RMM) |
                   ((raw.rm == RM_RUP) & !raw.sign) | ((raw.rm == RM_RDN) & raw.sign);

  always_comb begin
    out            = '0;
    flags          = '0;
    flags[FLAG_NV] = raw.nv;
    if (raw.isNaN) begin
      out = REC_CANON_NAN;
    end else begin
      flags[FLAG_DZ] = raw.dz;
      if (raw.isInf) begin
        out = {raw.sign, REC_EXP_INF, 23'b0};
      end else if (raw.isZero) begin
        out = {raw.sign, 32'b0};
      end else if (ovf) begin
        flags[FLAG_OF] = 1'b1;
        flags[FLAG_NX] = 1'b1;
        out = toInf ? {raw.sign, REC_EXP_INF, 23'b0} : {raw.sign, REC_EXP_MAX_FIN, 23'h7FFFFF};
      end else begin
        flags[FLAG_UF] = tinyAfter & inexact;
        flags[FLAG_NX] = inexact;
        if (tiny)
          out = (mr == '0) ? {raw.sign, 32'b0} : {raw.sign, eTiny, normSig};
        else
          out = {raw.sign, eNorm[8:0], mr[24] ? 23'b0 : mr[22:0]};
      end
    end
  end

endmodule

// File: rtl/div_sqrt_raw_to_rec_fn_out.sv
// Output stage of the F32 div/sqrt unit: S1 captures raw results, S2 holds the rounded
// recFN result on a valid/ready port; overruns are dropped and latched sticky.
module div_sqrt_raw_to_rec_fn_out
  import fpu_rec_pkg::*;
#(
  parameter int EXP_W = 8,
  parameter int SIG_W = 24,
  parameter int TAG_W = 5
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   io_rawValid_div,
  input  logic                   io_rawValid_sqrt,
  input  logic [2:0]             io_roundingMode,
  input  logic                   io_invalidExc,
  input  logic                   io_infiniteExc,
  input  logic                   io_raw_isNaN,
  input  logic                   io_raw_isInf,
  input  logic                   io_raw_isZero,
  input  logic                   io_raw_sign,
  input  logic [EXP_W+1:0]       io_raw_sExp,
  input  logic [SIG_W+2:0]       io_raw_sig,
  input  logic [TAG_W-1:0]       io_tag,
  output logic                   io_canIssue,
  output logic                   io_outValid,
  input  logic                   io_outReady,
  output logic [EXP_W+SIG_W:0]   io_out,
  output logic [4:0]             io_exceptionFlags,
  output logic                   io_outIsSqrt,
  output logic [TAG_W-1:0]       io_outTag,
  output logic                   io_overrun
);

  rawOp_t           rawIn, s1Op;
  logic             s1Valid, s1IsSqrt;
  logic [TAG_W-1:0] s1Tag;
  logic [32:0]      rndOut;
  logic [4:0]       rndFlags;
  logic             rawPulse, s2Load, s1Free;

  assign rawPulse    = io_rawValid_div | io_rawValid_sqrt;
  assign s2Load      = s1Valid & (!io_outValid | io_outReady);
  assign s1Free      = !s1Valid | s2Load;
  assign io_canIssue = !s1Valid & (!io_outValid | io_outReady);

  always_comb begin
    rawIn.isNaN  = io_raw_isNaN;
    rawIn.isInf  = io_raw_isInf;
    rawIn.isZero = io_raw_isZero;
    rawIn.sign   = io_raw_sign;
    rawIn.sExp   = io_raw_sExp;
    rawIn.sig    = io_raw_sig;
    rawIn.rm     = (io_roundingMode > 3'd4) ? RM_RNE : roundMode_t'(io_roundingMode);
    // Simultaneous div and sqrt pulses are a protocol error reported as invalid.
    rawIn.nv     = io_invalidExc | (io_rawValid_div & io_rawValid_sqrt);
    rawIn.dz     = io_infiniteExc;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      s1Valid    <= 1'b0;
      s1Op       <= '0;
      s1Tag      <= '0;
      s1IsSqrt   <= 1'b0;
      io_overrun <= 1'b0;
    end else if (rawPulse) begin
      if (s1Free) begin
        s1Valid  <= 1'b1;
        s1Op     <= rawIn;
        s1Tag    <= io_tag;
        s1IsSqrt <= io_rawValid_sqrt;
      end else begin
        io_overrun <= 1'b1;
      end
    end else if (s2Load) begin
      s1Valid <= 1'b0;
    end
  end

  rec_fn_round_core uRound (
    .raw  (s1Op),
    .out  (rndOut),
    .flags(rndFlags)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      io_outValid       <= 1'b0;
      io_out            <= '0;
      io_exceptionFlags <= '0;
      io_outTag         <= '0;
      io_outIsSqrt      <= 1'b0;
    end else if (s2Load) begin
      io_outValid       <= 1'b1;
      io_out            <= rndOut;
      io_exceptionFlags <= rndFlags;
      io_outTag         <= s1Tag;
      io_outIsSqrt      <= s1IsSqrt;
    end else if (io_outReady) begin
      io_outValid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_div_sqrt_raw_to_rec_fn_out.sv
// Directed bench for div_sqrt_raw_to_rec_fn_out: hand-rounded vectors, backpressure/overrun
// and asynchronous reset while busy.
module tb_div_sqrt_raw_to_rec_fn_out;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        io_rawValid_div = 1'b0, io_rawValid_sqrt = 1'b0;
  logic [2:0]  io_roundingMode = '0;
  logic        io_invalidExc = 1'b0, io_infiniteExc = 1'b0;
  logic        io_raw_isNaN = 1'b0, io_raw_isInf = 1'b0, io_raw_isZero = 1'b0, io_raw_sign = 1'b0;
  logic [9:0]  io_raw_sExp = '0;
  logic [26:0] io_raw_sig = '0;
  logic [4:0]  io_tag = '0;
  logic        io_canIssue, io_outValid, io_outIsSqrt, io_overrun;
  logic        io_outReady = 1'b1;
  logic [32:0] io_out;
  logic [4:0]  io_exceptionFlags, io_outTag;

  int nChk = 0;
  int nFail = 0;

  always #5 clock = ~clock;

  div_sqrt_raw_to_rec_fn_out #(.EXP_W(8), .SIG_W(24), .TAG_W(5)) dut (
    .clock(clock), .reset(reset),
    .io_rawValid_div(io_rawValid_div), .io_rawValid_sqrt(io_rawValid_sqrt),
    .io_roundingMode(io_roundingMode), .io_invalidExc(io_invalidExc),
    .io_infiniteExc(io_infiniteExc), .io_raw_isNaN(io_raw_isNaN),
    .io_raw_isInf(io_raw_isInf), .io_raw_isZero(io_raw_isZero),
    .io_raw_sign(io_raw_sign), .io_raw_sExp(io_raw_sExp), .io_raw_sig(io_raw_sig),
    .io_tag(io_tag), .io_canIssue(io_canIssue), .io_outValid(io_outValid),
    .io_outReady(io_outReady), .io_out(io_out), .io_exceptionFlags(io_exceptionFlags),
    .io_outIsSqrt(io_outIsSqrt), .io_outTag(io_outTag), .io_overrun(io_overrun)
  );

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    nChk++;
    if (act !== exp) begin
      nFail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic drive(input logic d, input logic s, input logic [2:0] rm, input logic sgn,
                       input logic nan, input logic inf, input logic zero, input logic nv,
                       input logic dz, input logic [9:0] se, input logic [26:0] sg,
                       input logic [4:0] tg);
    io_rawValid_div  = d;
    io_rawValid_sqrt = s;
    io_roundingMode  = rm;
    io_raw_sign      = sgn;
    io_raw_isNaN     = nan;
    io_raw_isInf     = inf;
    io_raw_isZero    = zero;
    io_invalidExc    = nv;
    io_infiniteExc   = dz;
    io_raw_sExp      = se;
    io_raw_sig       = sg;
    io_tag           = tg;
  endtask

  task automatic idle();
    io_rawValid_div  = 1'b0;
    io_rawValid_sqrt = 1'b0;
  endtask

  // Pulse in cycle N, S1 busy in N+1, result visible in N+2 (ready held high).
  task automatic runVec(input string nm, input logic d, input logic s, input logic [2:0] rm,
                        input logic sgn, input logic nan, input logic inf, input logic zero,
                        input logic nv, input logic dz, input logic [9:0] se,
                        input logic [26:0] sg, input logic [32:0] eo, input logic [4:0] ef,
                        input logic [4:0] tg);
    @(negedge clock);
    drive(d, s, rm, sgn, nan, inf, zero, nv, dz, se, sg, tg);
    @(negedge clock);
    idle();
    chk({nm, ".lat1"}, 64'(io_outValid), 64'd0);
    chk({nm, ".busy"}, 64'(io_canIssue), 64'd0);
    @(negedge clock);
    chk({nm, ".valid"}, 64'(io_outValid), 64'd1);
    chk({nm, ".out"}, 64'(io_out), 64'(eo));
    chk({nm, ".flags"}, 64'(io_exceptionFlags), 64'(ef));
    chk({nm, ".tag"}, 64'(io_outTag), 64'(tg));
    chk({nm, ".sqrt"}, 64'(io_outIsSqrt), 64'(s));
  endtask

  initial begin
    repeat (2) @(negedge clock);
    chk("rst.valid", 64'(io_outValid), 64'd0);
    chk("rst.canIssue", 64'(io_canIssue), 64'd1);
    chk("rst.overrun", 64'(io_overrun), 64'd0);
    chk("rst.out", 64'(io_out), 64'd0);
    chk("rst.flags", 64'(io_exceptionFlags), 64'd0);
    chk("rst.tag", 64'(io_outTag), 64'd0);
    chk("rst.sqrt", 64'(io_outIsSqrt), 64'd0);
    reset = 1'b1;
    @(negedge clock);
    chk("idle.canIssue", 64'(io_canIssue), 64'd1);

    //      name          d  s  rm  sg nan inf zr nv dz sExp    sig            out            flags  tag
    runVec("one_rne",    1, 0, 0,  0, 0,  0,  0, 0, 0, 10'h100, 27'h2000000, 33'h080000000, 5'h00, 5'd1);
    runVec("third_rne",  1, 0, 0,  0, 0,  0,  0, 0, 0, 10'h0FE, 27'h2AAAAAB, 33'h07F2AAAAB, 5'h01, 5'd2);
    runVec("third_rtz",  1, 0, 1,  0, 0,  0,  0, 0, 0, 10'h0FE, 27'h2AAAAAB, 33'h07F2AAAAA, 5'h01, 5'd3);
    runVec("third_rm7",  1, 0, 7,  0, 0,  0,  0, 0, 0, 10'h0FE, 27'h2AAAAAB, 33'h07F2AAAAB, 5'h01, 5'd4);
    runVec("ovf_rne",    1, 0, 0,  0, 0,  0,  0, 0, 0, 10'h180, 27'h2000000, 33'h0C0000000, 5'h05, 5'd5);
    runVec("ovf_rtz",    0, 1, 1,  0, 0,  0,  0, 0, 0, 10'h180, 27'h2000000, 33'h0BFFFFFFF, 5'h05, 5'd6);
    runVec("ovf_rup_neg",1, 0, 3,  1, 0,  0,  0, 0, 0, 10'h180, 27'h2000000, 33'h1BFFFFFFF, 5'h05, 5'd7);
    runVec("inf_dz",     1, 0, 0,  0, 0,  1,  0, 0, 1, 10'h000, 27'h0000000, 33'h0C0000000, 5'h08, 5'd8);
    runVec("nan_nv",     0, 1, 0,  0, 1,  0,  0, 1, 0, 10'h000, 27'h0000000, 33'h0E0400000, 5'h10, 5'd9);
    runVec("zero_neg",   1, 0, 0,  1, 0,  0,  1, 0, 0, 10'h000, 27'h0000000, 33'h100000000, 5'h00, 5'd10);
    runVec("carry_exp",  1, 0, 0,  0, 0,  0,  0, 0, 0, 10'h100, 27'h3FFFFFE, 33'h080800000, 5'h01, 5'd11);
    runVec("sig26_tie",  1, 0, 0,  0, 0,  0,  0, 0, 0, 10'h100, 27'h4000004, 33'h080800000, 5'h01, 5'd12);
    runVec("sig26_rmm",  1, 0, 4,  0, 0,  0,  0, 0, 0, 10'h100, 27'h4000004, 33'h080800001, 5'h01, 5'd13);
    runVec("sub_exact",  1, 0, 0,  0, 0,  0,  0, 0, 0, 10'h081, 27'h2000000, 33'h040800000, 5'h00, 5'd14);
    runVec("sub_inexact",1, 0, 0,  0, 0,  0,  0, 0, 0, 10'h081, 27'h2000003, 33'h040800000, 5'h03, 5'd15);
    runVec("sub_to_norm",1, 0, 0,  0, 0,  0,  0, 0, 0, 10'h081, 27'h3FFFFFF, 33'h041000000, 5'h01, 5'd16);
    runVec("sub_rtz",    1, 0, 1,  0, 0,  0,  0, 0, 0, 10'h081, 27'h3FFFFFF, 33'h040FFFFFE, 5'h03, 5'd17);
    runVec("both_pulse", 1, 1, 0,  0, 0,  0,  0, 0, 0, 10'h100, 27'h2000000, 33'h080000000, 5'h10, 5'd18);

    @(negedge clock);
    chk("drain.valid", 64'(io_outValid), 64'd0);

    // Backpressure: three back-to-back pulses with the consumer stalled.
    io_outReady = 1'b0;
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 10'h100, 27'h2000000, 5'd1);
    @(negedge clock);
    io_tag = 5'd2;
    @(negedge clock);
    io_tag = 5'd3;
    @(negedge clock);
    idle();
    chk("ovr.valid", 64'(io_outValid), 64'd1);
    chk("ovr.tagA", 64'(io_outTag), 64'd1);
    chk("ovr.overrun", 64'(io_overrun), 64'd1);
    chk("ovr.canIssue", 64'(io_canIssue), 64'd0);
    @(negedge clock);
    chk("ovr.holdTag", 64'(io_outTag), 64'd1);
    chk("ovr.holdOut", 64'(io_out), 64'h080000000);
    chk("ovr.holdCan", 64'(io_canIssue), 64'd0);
    io_outReady = 1'b1;
    @(negedge clock);
    chk("ovr.tagB", 64'(io_outTag), 64'd2);
    chk("ovr.validB", 64'(io_outValid), 64'd1);
    chk("ovr.canIssueB", 64'(io_canIssue), 64'd1);
    chk("ovr.sticky", 64'(io_overrun), 64'd1);
    @(negedge clock);
    chk("ovr.noC", 64'(io_outValid), 64'd0);
    @(negedge clock);
    chk("ovr.noC2", 64'(io_outValid), 64'd0);

    // Asynchronous reset while both stages hold work.
    io_outReady = 1'b0;
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 10'h100, 27'h2000000, 5'd7);
    @(negedge clock);
    io_tag = 5'd8;
    @(negedge clock);
    idle();
    chk("mrst.pre.valid", 64'(io_outValid), 64'd1);
    chk("mrst.pre.canIssue", 64'(io_canIssue), 64'd0);
    #2 reset = 1'b0;
    #1;
    chk("mrst.valid", 64'(io_outValid), 64'd0);
    chk("mrst.canIssue", 64'(io_canIssue), 64'd1);
    chk("mrst.overrun", 64'(io_overrun), 64'd0);
    @(negedge clock);
    reset = 1'b1;
    io_outReady = 1'b1;
    repeat (3) begin
      @(negedge clock);
      chk("mrst.quiet", 64'(io_outValid), 64'd0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", nChk, nFail);
    $finish;
  end

endmodule
